// File: rtl/pwm_ramp_ctrl_if.sv
// APB-style register bus, used both for the processor port and the PWM write port.
interface pwm_ramp_ctrl_if;
  logic       PSEL;
  logic       PWrite;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;

  modport master (output PSEL, PWrite, PADDR, PWDATA, input PRDATA);
  modport slave  (input PSEL, PWrite, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: steps the PWM duty one count per programmed interval
// from its current value to a target, for soft-start/soft-stop of PWM loads.
module pwm_ramp_ctrl #(
  parameter int DUTY_MAX = 10,
  parameter int STEP_W   = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  pwm_ramp_ctrl_if.slave  apb,
  pwm_ramp_ctrl_if.master pwm,
  output logic            BUSY,
  output logic            DONE
);

  localparam logic [3:0] DUTY_LIM  = 4'(DUTY_MAX);
  localparam logic [3:0] DUTY_RST  = 4'd5;
  localparam logic [7:0] A_CTRL    = 8'h00;
  localparam logic [7:0] A_TARGET  = 8'h01;
  localparam logic [7:0] A_STEP_LO = 8'h02;
  localparam logic [7:0] A_STEP_HI = 8'h03;
  localparam logic [7:0] A_STATUS  = 8'h04;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic              en_q;
  logic [3:0]        target_q;
  logic [15:0]       step_q;
  logic [3:0]        cur_q, cur_d;
  logic [STEP_W-1:0] cnt_q, cnt_d, interval;
  logic              done_q, done_d;
  logic              m_sel_q, m_sel_d;
  logic [3:0]        m_duty_q, m_duty_d;
  logic              wr_en, go_start;
  logic [3:0]        step_toward;
  logic [7:0]        rdata;

  assign wr_en    = apb.PSEL && apb.PWrite;
  // GO only starts a ramp when the same CTRL write also leaves EN set.
  assign go_start = wr_en && (apb.PADDR == A_CTRL) && apb.PWDATA[1] && apb.PWDATA[0];
  assign interval = (step_q == 16'd0) ? STEP_W'(1) : STEP_W'(step_q);
  // Direction is re-evaluated at every step so a mid-ramp TARGET change just steers.
  assign step_toward = (target_q > cur_q) ? cur_q + 4'd1 : cur_q - 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      en_q     <= 1'b0;
      target_q <= DUTY_RST;
      step_q   <= '0;
    end else if (wr_en) begin
      case (apb.PADDR)
        A_CTRL:    en_q         <= apb.PWDATA[0];
        A_TARGET:  target_q     <= (apb.PWDATA[3:0] > DUTY_LIM) ? DUTY_LIM : apb.PWDATA[3:0];
        A_STEP_LO: step_q[7:0]  <= apb.PWDATA;
        A_STEP_HI: step_q[15:8] <= apb.PWDATA;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q  <= S_IDLE;
      cur_q    <= DUTY_RST;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      m_sel_q  <= 1'b0;
      m_duty_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      m_sel_q  <= m_sel_d;
      m_duty_q <= m_duty_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    m_sel_d  = 1'b0;
    m_duty_d = '0;
    case (state_q)
      S_IDLE: begin
        if (go_start) begin
          if (cur_q == target_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = interval;
          end
        end
      end
      S_WAIT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (cnt_q <= STEP_W'(1)) begin
          if (cur_q == target_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_WRITE;
            m_sel_d  = 1'b1;
            m_duty_d = step_toward;
          end
        end else begin
          cnt_d = cnt_q - STEP_W'(1);
        end
      end
      S_WRITE: begin
        // The PWM write is on the bus this cycle, so CUR tracks it unconditionally.
        cur_d = m_duty_q;
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (m_duty_q == target_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = interval;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = done_q;
  assign pwm.PSEL   = m_sel_q;
  assign pwm.PWrite = m_sel_q;
  assign pwm.PADDR  = 8'h00;
  assign pwm.PWDATA = {4'b0000, m_duty_q};

  always_comb begin
    rdata = '0;
    if (apb.PSEL && !apb.PWrite) begin
      case (apb.PADDR)
        A_CTRL:    rdata = {7'd0, en_q};
        A_TARGET:  rdata = {4'd0, target_q};
        A_STEP_LO: rdata = step_q[7:0];
        A_STEP_HI: rdata = step_q[15:8];
        A_STATUS:  rdata = {cur_q, 3'b000, BUSY};
        default:   rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA = rdata;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: register access, ramp sequences, retarget,
// EN abort, GO-while-busy, clamping and asynchronous reset.
module tb_pwm_ramp_ctrl;

  logic PCLK;
  logic PRESETn;
  logic busy;
  logic done;

  pwm_ramp_ctrl_if apb ();
  pwm_ramp_ctrl_if pwm ();

  pwm_ramp_ctrl dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (apb),
    .pwm     (pwm),
    .BUSY    (busy),
    .DONE    (done)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cyc   = 0;
  int go       = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int bad_cnt  = 0;
  logic [7:0] wq_data[$];
  int         wq_cyc[$];

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  // Records PWM writes, DONE pulses and BUSY cycles away from the active edge.
  always @(negedge PCLK) begin
    if (pwm.PSEL === 1'b1) begin
      wq_data.push_back(pwm.PWDATA);
      wq_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (pwm.PWrite !== pwm.PSEL || pwm.PADDR !== 8'h00 ||
        (pwm.PSEL !== 1'b1 && pwm.PWDATA !== 8'h00))
      bad_cnt <= bad_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge PCLK);
    apb.PSEL = 1'b1; apb.PWrite = 1'b1; apb.PADDR = a; apb.PWDATA = d;
    wr_cyc = cyc;
    @(negedge PCLK);
    apb.PSEL = 1'b0; apb.PWrite = 1'b0;
    #1;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    @(negedge PCLK);
    apb.PSEL = 1'b1; apb.PWrite = 1'b0; apb.PADDR = a;
    #1 d = apb.PRDATA;
    apb.PSEL = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic clear_log();
    wq_data.delete();
    wq_cyc.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    while (wq_data.size() < n && k < 300) begin
      @(negedge PCLK); #1; k++;
    end
    check(tag, (wq_data.size() >= n), 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt < 1 && k < 300) begin
      @(negedge PCLK); #1; k++;
    end
    check(tag, (done_cnt >= 1), 1);
    repeat (4) @(negedge PCLK);
    #1;
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PWrite = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b0;

    // Reset state
    rd_chk(8'h04, 8'h50, "rst_status");
    rd_chk(8'h01, 8'h05, "rst_target");
    rd_chk(8'h00, 8'h00, "rst_ctrl");
    rd_chk(8'h02, 8'h00, "rst_step_lo");
    rd_chk(8'h07, 8'h00, "rst_unmapped");
    check("rst_m_psel", pwm.PSEL, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    wr(8'h05, 8'hFF);
    rd_chk(8'h04, 8'h50, "ro_status_write");

    // Ramp up 5 -> 9, STEP=3
    wr(8'h01, 8'h09);
    wr(8'h02, 8'h03);
    rd_chk(8'h02, 8'h03, "step_lo_rb");
    clear_log();
    wr(8'h00, 8'h03);
    go = wr_cyc;
    wait_done("up_done_seen");
    check("up_nwrites", wq_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq_data.size()) begin
        check($sformatf("up_data%0d", i), wq_data[i], 8'(6 + i));
        check($sformatf("up_cyc%0d", i), wq_cyc[i], go + 4 + 4 * i);
      end
    end
    check("up_done_cnt", done_cnt, 1);
    check("up_done_cyc", done_cyc, go + 17);
    check("up_busy_cycles", busy_cnt, 16);
    rd_chk(8'h04, 8'h90, "up_status");
    rd_chk(8'h00, 8'h01, "up_ctrl_go_reads0");

    // Ramp down 9 -> 2, STEP=0 treated as 1
    wr(8'h01, 8'h02);
    wr(8'h02, 8'h00);
    clear_log();
    wr(8'h00, 8'h03);
    go = wr_cyc;
    wait_done("dn_done_seen");
    check("dn_nwrites", wq_data.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < wq_data.size()) begin
        check($sformatf("dn_data%0d", i), wq_data[i], 8'(8 - i));
        check($sformatf("dn_cyc%0d", i), wq_cyc[i], go + 2 + 2 * i);
      end
    end
    check("dn_done_cnt", done_cnt, 1);
    check("dn_busy_cycles", busy_cnt, 14);
    rd_chk(8'h04, 8'h20, "dn_status");

    // Back to 5, then retarget mid-ramp 5 -> 9 down to 6
    wr(8'h01, 8'h05);
    clear_log();
    wr(8'h00, 8'h03);
    wait_done("pre_rt_done");
    wr(8'h02, 8'h03);
    wr(8'h01, 8'h09);
    clear_log();
    wr(8'h00, 8'h03);
    go = wr_cyc;
    wait_writes(2, "rt_two_writes");
    wr(8'h01, 8'h06);
    wait_done("rt_done_seen");
    check("rt_nwrites", wq_data.size(), 3);
    if (wq_data.size() == 3) begin
      check("rt_data0", wq_data[0], 8'd6);
      check("rt_data1", wq_data[1], 8'd7);
      check("rt_data2", wq_data[2], 8'd6);
      check("rt_cyc2", wq_cyc[2], go + 12);
    end
    check("rt_done_cnt", done_cnt, 1);
    rd_chk(8'h04, 8'h60, "rt_status");

    // GO while busy ignored, then EN cleared mid-ramp 6 -> 10
    wr(8'h01, 8'h0A);
    clear_log();
    wr(8'h00, 8'h03);
    go = wr_cyc;
    wait_writes(1, "ab_first_write");
    wr(8'h00, 8'h03);
    wait_writes(2, "ab_second_write");
    wr(8'h00, 8'h00);
    repeat (20) @(negedge PCLK);
    #1;
    check("ab_nwrites", wq_data.size(), 2);
    if (wq_data.size() == 2) begin
      check("ab_data1", wq_data[1], 8'd8);
      check("ab_cyc1", wq_cyc[1], go + 8);
    end
    check("ab_done_cnt", done_cnt, 0);
    check("ab_busy", busy, 1'b0);
    rd_chk(8'h04, 8'h80, "ab_status");

    // TARGET clamp: 15 stored as 10
    wr(8'h01, 8'h0F);
    rd_chk(8'h01, 8'h0A, "clamp_target");
    wr(8'h02, 8'h00);
    clear_log();
    wr(8'h00, 8'h03);
    wait_done("clamp_done_seen");
    check("clamp_nwrites", wq_data.size(), 2);
    if (wq_data.size() == 2) check("clamp_last", wq_data[1], 8'd10);
    rd_chk(8'h04, 8'hA0, "clamp_status");

    // GO with CUR==TARGET: DONE next cycle, never busy
    clear_log();
    wr(8'h00, 8'h03);
    go = wr_cyc;
    repeat (4) @(negedge PCLK);
    #1;
    check("eq_done_cnt", done_cnt, 1);
    check("eq_done_cyc", done_cyc, go + 1);
    check("eq_busy_cycles", busy_cnt, 0);

    // GO with EN=0 does nothing
    clear_log();
    wr(8'h00, 8'h02);
    repeat (4) @(negedge PCLK);
    #1;
    check("noen_done_cnt", done_cnt, 0);
    check("noen_busy_cycles", busy_cnt, 0);

    check("m_bus_clean", bad_cnt, 0);

    // Asynchronous reset while a PWM write is on the bus
    wr(8'h01, 8'h00);
    wr(8'h02, 8'h03);
    clear_log();
    wr(8'h00, 8'h03);
    wait_writes(1, "rs_first_write");
    PRESETn = 1'b1;
    #1;
    check("rs_m_psel", pwm.PSEL, 1'b0);
    check("rs_m_pwdata", pwm.PWDATA, 8'h00);
    check("rs_busy", busy, 1'b0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    rd_chk(8'h04, 8'h50, "rs_status");
    rd_chk(8'h01, 8'h05, "rs_target");
    rd_chk(8'h00, 8'h00, "rs_ctrl");
    rd_chk(8'h02, 8'h00, "rs_step");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
